// File: rtl/elevator_fsm.sv
// Two-floor elevator controller: latches calls, sequences travel between floors, times
// travel and door dwell, and drives the state/counting_value pair read by motor_ctrl.
//
//  state      | meaning
//  IDLE       | just out of reset, car assumed at floor 1
//  FLOOR1     | parked at floor 1; door open while counting_value != 0
//  FLOOR2     | parked at floor 2; door open while counting_value != 0
//  GOING_TO_1 | travelling down; motor runs while counting_value != 0
//  GOING_TO_2 | travelling up; motor runs while counting_value != 0
module elevator_fsm #(
    parameter logic [2:0] TRAVEL_TIME = 3'd5,
    parameter logic [2:0] DOOR_TIME   = 3'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_floor1,
    input  logic       btn_floor2,
    output logic [2:0] state,
    output logic [2:0] counting_value,
    output logic       door_open,
    output logic       pend1,
    output logic       pend2
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FLOOR1     = 3'd1,
        FLOOR2     = 3'd2,
        GOING_TO_1 = 3'd3,
        GOING_TO_2 = 3'd4
    } state_t;

    state_t     state_q;
    logic [2:0] cv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cv_q    <= 3'd0;
            pend1   <= 1'b0;
            pend2   <= 1'b0;
        end else begin
            // A call at the floor the car is parked at re-opens the door instead of latching.
            if (btn_floor1 && state_q != FLOOR1) pend1 <= 1'b1;
            if (btn_floor2 && state_q != FLOOR2) pend2 <= 1'b1;

            case (state_q)
                IDLE: begin
                    state_q <= FLOOR1;
                    cv_q    <= 3'd0;
                end
                FLOOR1: begin
                    if (btn_floor1) begin
                        cv_q <= DOOR_TIME;
                    end else if (cv_q != 3'd0) begin
                        if (tick) cv_q <= cv_q - 3'd1;
                    end else if (pend2) begin
                        state_q <= GOING_TO_2;
                        cv_q    <= TRAVEL_TIME;
                    end
                end
                FLOOR2: begin
                    if (btn_floor2) begin
                        cv_q <= DOOR_TIME;
                    end else if (cv_q != 3'd0) begin
                        if (tick) cv_q <= cv_q - 3'd1;
                    end else if (pend1) begin
                        state_q <= GOING_TO_1;
                        cv_q    <= TRAVEL_TIME;
                    end
                end
                GOING_TO_1: begin
                    // Arrival clear overrides a same-cycle set above.
                    if (cv_q == 3'd0) begin
                        state_q <= FLOOR1;
                        cv_q    <= DOOR_TIME;
                        pend1   <= 1'b0;
                    end else if (tick) begin
                        cv_q <= cv_q - 3'd1;
                    end
                end
                GOING_TO_2: begin
                    if (cv_q == 3'd0) begin
                        state_q <= FLOOR2;
                        cv_q    <= DOOR_TIME;
                        pend2   <= 1'b0;
                    end else if (tick) begin
                        cv_q <= cv_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cv_q    <= 3'd0;
                end
            endcase
        end
    end

    assign state          = state_q;
    assign counting_value = cv_q;
    assign door_open      = ((state_q == FLOOR1) || (state_q == FLOOR2)) && (cv_q != 3'd0);

endmodule

// File: tb/tb_elevator_fsm.sv
// Directed bench for elevator_fsm: walks the call/travel/dwell scenarios and an async reset
// mid-travel, comparing every output against hand-computed values.
module tb_elevator_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       btn_floor1 = 1'b0;
    logic       btn_floor2 = 1'b0;
    logic [2:0] state;
    logic [2:0] counting_value;
    logic       door_open;
    logic       pend1;
    logic       pend2;

    int errors = 0;
    int checks = 0;

    elevator_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .btn_floor1     (btn_floor1),
        .btn_floor2     (btn_floor2),
        .state          (state),
        .counting_value (counting_value),
        .door_open      (door_open),
        .pend1          (pend1),
        .pend2          (pend2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic t, input logic b1, input logic b2);
        tick       = t;
        btn_floor1 = b1;
        btn_floor2 = b2;
        @(posedge clk);
        #1;
        tick       = 1'b0;
        btn_floor1 = 1'b0;
        btn_floor2 = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic expect_all(input string tag, input logic [2:0] s, input logic [2:0] cv,
                              input logic d, input logic p1, input logic p2);
        check({tag, ".state"}, {1'b0, state}, {1'b0, s});
        check({tag, ".cv"},    {1'b0, counting_value}, {1'b0, cv});
        check({tag, ".door"},  {3'b0, door_open}, {3'b0, d});
        check({tag, ".pend1"}, {3'b0, pend1}, {3'b0, p1});
        check({tag, ".pend2"}, {3'b0, pend2}, {3'b0, p2});
    endtask

    initial begin
        #22;
        expect_all("reset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Scenario 1: come up at floor 1, door closed, and stay there.
        step(1'b0, 1'b0, 1'b0);
        expect_all("s1_up", 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        ticks(20);
        expect_all("s1_hold", 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);

        // Scenario 2: call floor 2 from a closed door at floor 1.
        step(1'b0, 1'b0, 1'b1);
        check("s2_pend2", {3'b0, pend2}, 4'd1);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s2_depart", 3'd4, 3'd5, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("s2_travel_cv", {1'b0, counting_value}, 4'(5 - i));
        end
        check("s2_still_moving", {1'b0, state}, 4'd4);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s2_arrive", 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);

        // Scenario 3: re-open at floor 2 with a pending floor-1 call.
        ticks(1);
        check("s3_cv2", {1'b0, counting_value}, 4'd2);
        step(1'b0, 1'b1, 1'b0);
        expect_all("s3_call1", 3'd2, 3'd2, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        expect_all("s3_reopen", 3'd2, 3'd3, 1'b1, 1'b1, 1'b0);
        ticks(3);
        expect_all("s3_closed", 3'd2, 3'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s3_depart", 3'd3, 3'd5, 1'b0, 1'b1, 1'b0);
        ticks(5);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s3_arrive1", 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);

        // Scenario 4: a floor-1 call during the upward trip does not reverse it.
        step(1'b0, 1'b0, 1'b1);
        check("s4_pend2", {3'b0, pend2}, 4'd1);
        ticks(3);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s4_depart", 3'd4, 3'd5, 1'b0, 1'b0, 1'b1);
        ticks(1);
        step(1'b0, 1'b1, 1'b0);
        expect_all("s4_call_in_travel", 3'd4, 3'd4, 1'b0, 1'b1, 1'b1);
        ticks(4);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s4_arrive2", 3'd2, 3'd3, 1'b1, 1'b1, 1'b0);
        ticks(3);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s4_return", 3'd3, 3'd5, 1'b0, 1'b1, 1'b0);
        ticks(5);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s4_arrive1", 3'd1, 3'd3, 1'b1, 1'b0, 1'b0);

        // Scenario 5: both buttons together at a closed floor-1 door.
        ticks(3);
        expect_all("s5_closed", 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        expect_all("s5_both", 3'd1, 3'd3, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("s5_waits", {1'b0, state}, 4'd1);
        ticks(3);
        step(1'b0, 1'b0, 1'b0);
        expect_all("s5_depart", 3'd4, 3'd5, 1'b0, 1'b0, 1'b1);

        // Scenario 6: async reset mid-travel, tick and call in the same cycle first.
        step(1'b1, 1'b1, 1'b0);
        expect_all("s6_tick_call", 3'd4, 3'd4, 1'b0, 1'b1, 1'b1);
        ticks(2);
        check("s6_cv2", {1'b0, counting_value}, 4'd2);
        #2 rst = 1'b0;
        #1;
        expect_all("s6_async", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_all("s6_held", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        expect_all("s6_up", 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
